switch_game_core: RTL
=====================

# switch_game_core

Parametrised core of the switch reaction game: prompts the player through LEDs to toggle one switch at a time, judges each move after a settle window, keeps score against a countdown, and tracks a session high score. It sits between the board's raw switch inputs and the LED and seven-segment display logic. The display decoding stays outside this block.

## Interface
- `N_SW`, 10: number of switches and LEDs, valid range 2–16.
- `SCORE_W`, 7: score width; the score saturates at 2^SCORE_W−1.
- `TIME_W`, 6: width of `time_left`.
- `GAME_SECONDS`, 20: round length in seconds, must be greater than 0.
- `TICK_CYCLES`, 50_000_000: clk cycles per one-second tick.
- `SETTLE_CYCLES`, 500_000: cycles the synchronised switches must stay stable before a move is judged.
- `LFSR_SEED`, 16'hACE1: LFSR reset value, must be non-zero.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  single-cycle pulse that begins a game.
- `sw`  in  N_SW  raw, asynchronous switch levels.
- `led`  out  N_SW  prompt mask.
- `score`  out  SCORE_W  current score.
- `high_score`  out  SCORE_W  best score since reset.
- `time_left`  out  TIME_W  seconds remaining.
- `playing`  out  1  high while in PROMPT, WAIT or SETTLE.
- `game_over`  out  1  high while in OVER.
- `timed_out`  out  1  set when the game ended on time; cleared by `start` or reset.

## Operation
- **Switch sampling:** `sw` passes through a 2-flop synchroniser to give `sw_s`. All judgements use `sw_s`.
- **Random source:** a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
  - Candidate index = `lfsr[7:0] % N_SW`.
  - If the candidate equals the previous index, use `(candidate+1) % N_SW` instead.
- **IDLE** (reset state):
  - `led` = 0.
  - `start` moves to PROMPT, clears `score`, clears `timed_out`, loads `time_left` = GAME_SECONDS and clears the tick prescaler.
- **PROMPT** (1 cycle):
  - `mask` = one-hot(index); `base` = `sw_s`; `expected` = `sw_s ^ mask`; `led` = `mask`.
  - Go to WAIT.
- **WAIT:**
  - When `sw_s != base`, go to SETTLE and load the settle counter with SETTLE_CYCLES−1.
- **SETTLE:**
  - Any change of `sw_s` reloads the settle counter.
  - When the counter reaches 0 with `sw_s == expected`: `score`+1 (saturating), then go to PROMPT.
  - When the counter reaches 0 with `sw_s == base` (player toggled back): return to WAIT with no penalty.
  - Any other value at expiry: go to OVER.
- **OVER:**
  - `led` = all ones.
  - `high_score` = max(`high_score`, `score`), updated on the entry cycle.
  - `start` restarts exactly as from IDLE.
- **Timer:**
  - The prescaler counts clk cycles only while `playing`.
  - On each tick `time_left` decrements.
  - When a tick would make `time_left` reach 0, go to OVER and set `timed_out`=1.
- **`start` handling:** `start` is ignored while `playing`.

## Timing
- **Reset values:** state=IDLE, `led`=0, `score`=0, `high_score`=0, `time_left`=GAME_SECONDS, `playing`=0, `game_over`=0, `timed_out`=0, LFSR=LFSR_SEED.
- **Start:** `start` sampled at edge k gives `playing`=1 and PROMPT at k+1, and a valid `led` at k+2.
- **Move latency:** a `sw` edge reaches `sw_s` after 2 cycles. A correct move is scored SETTLE_CYCLES+3 cycles after the raw edge, and the next `led` mask is visible 1 cycle after that.
- **Tick period:** the first tick falls TICK_CYCLES cycles after entering PROMPT from `start`. Game length is exactly GAME_SECONDS×TICK_CYCLES playing cycles.
- **Simultaneous timeout and correct judgement:** timeout wins, the score is not incremented, and `high_score` uses the un-incremented score.
- **Saturation:** at max, `score` holds and play continues.
- **Reset mid-game:** the block returns to reset values immediately, including `high_score`.

## Configuration
- **`SWGAME_HISCORE_EN` defined:** the high-score register and max-update on OVER entry are present as described.
- **`SWGAME_HISCORE_EN` undefined:** no high-score register is built and `high_score` is tied to 0. All other behaviour is unchanged.

## Test plan
All scenarios use N_SW=10, TICK_CYCLES=100, SETTLE_CYCLES=4, GAME_SECONDS=3 and `SWGAME_HISCORE_EN` defined.
- **Reset then idle:** hold `reset` 3 cycles with `sw`=0 → `led`=0, `time_left`=3, `playing`=0. Ten further idle cycles → no change.
- **Correct moves:** pulse `start`, then toggle exactly the lit switch each prompt, 5 times → `score`=5. Consecutive `led` masks are one-hot and never repeat back-to-back.
- **Wrong switch:** with `led`=10'b0000001000, toggle `sw[0]` → after 4+3 cycles `game_over`=1, `led`=10'h3FF, `high_score`=current `score`, `timed_out`=0.
- **Bounce:** toggle the lit switch, then toggle it back within 2 cycles → return to WAIT with `score` unchanged. Toggle it again and hold → `score`+1.
- **Timeout:** start and make no moves → after 300 cycles `game_over`=1, `timed_out`=1, `time_left`=0. Pulse `start` → `time_left`=3, `score`=0, `high_score` retained.
- **Timeout/judgement collision:** align a correct judgement with the final tick → OVER with `score` not incremented and `timed_out`=1.

Source files
------------

// File: rtl/switch_game_core.sv
// switch_game_core: switch reaction game core (prompt, settle-judged moves, score, countdown).
// Define SWGAME_HISCORE_EN to build the session high-score register; otherwise high_score reads 0.
module switch_game_core #(
    parameter int          N_SW          = 10,
    parameter int          SCORE_W       = 7,
    parameter int          TIME_W        = 6,
    parameter int          GAME_SECONDS  = 20,
    parameter int          TICK_CYCLES   = 50_000_000,
    parameter int          SETTLE_CYCLES = 500_000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N_SW-1:0]    sw,
    output logic [N_SW-1:0]    led,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [TIME_W-1:0]  time_left,
    output logic               playing,
    output logic               game_over,
    output logic               timed_out
);
    localparam int PRE_W = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
    localparam int SET_W = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, PROMPT, WAIT, SETTLE, OVER} state_t;

    state_t            state;
    logic [15:0]       lfsr;
    logic [N_SW-1:0]   sw_m, sw_s, sw_last, base, expected, mask;
    logic [7:0]        cand, idx, prev;
    logic [PRE_W-1:0]  presc;
    logic [SET_W-1:0]  cnt;
    logic              tick, timeout, expire, hit, back;

    always_comb begin
        cand    = lfsr[7:0] % 8'(N_SW);
        idx     = cand == prev ? 8'((cand + 8'd1) % 8'(N_SW)) : cand;
        mask    = N_SW'(1) << idx;
        tick    = playing && presc == PRE_W'(TICK_CYCLES - 1);
        timeout = tick && time_left == TIME_W'(1);
        expire  = state == SETTLE && sw_s == sw_last && cnt == '0;
        hit     = expire && sw_s == expected;
        back    = expire && sw_s == base;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lfsr      <= LFSR_SEED;
            sw_m      <= '0;
            sw_s      <= '0;
            sw_last   <= '0;
            base      <= '0;
            expected  <= '0;
            prev      <= 8'hFF;
            presc     <= '0;
            cnt       <= '0;
            led       <= '0;
            score     <= '0;
            time_left <= TIME_W'(GAME_SECONDS);
            playing   <= 1'b0;
            game_over <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            sw_m    <= sw;
            sw_s    <= sw_m;
            sw_last <= sw_s;
            if (playing) presc <= tick ? '0 : presc + 1'b1;
            if (tick) time_left <= time_left - 1'b1;
            // The final tick pre-empts whatever the FSM would have done this cycle.
            if (timeout) begin
                state     <= OVER;
                playing   <= 1'b0;
                game_over <= 1'b1;
                timed_out <= 1'b1;
                led       <= '1;
            end else begin
                case (state)
                    IDLE, OVER: if (start) begin
                        state     <= PROMPT;
                        playing   <= 1'b1;
                        game_over <= 1'b0;
                        timed_out <= 1'b0;
                        score     <= '0;
                        time_left <= TIME_W'(GAME_SECONDS);
                        presc     <= '0;
                        led       <= '0;
                    end
                    PROMPT: begin
                        led      <= mask;
                        base     <= sw_s;
                        expected <= sw_s ^ mask;
                        prev     <= idx;
                        state    <= WAIT;
                    end
                    WAIT: if (sw_s != base) begin
                        state <= SETTLE;
                        cnt   <= SET_W'(SETTLE_CYCLES - 1);
                    end
                    SETTLE: begin
                        if (sw_s != sw_last) cnt <= SET_W'(SETTLE_CYCLES - 1);
                        else if (cnt != '0) cnt <= cnt - 1'b1;
                        else if (hit) begin
                            score <= &score ? score : score + 1'b1;
                            state <= PROMPT;
                        end else if (back) state <= WAIT;
                        else begin
                            state     <= OVER;
                            playing   <= 1'b0;
                            game_over <= 1'b1;
                            led       <= '1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SWGAME_HISCORE_EN
    logic [SCORE_W-1:0] best;

    // Every way into OVER: final tick, or a settled value that is neither target nor origin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) best <= '0;
        else if (timeout || (expire && !hit && !back)) best <= score > best ? score : best;
    end

    assign high_score = best;
`else
    assign high_score = '0;
`endif
endmodule
